// File: rtl/quadrature_decoder_counter.sv
`default_nettype none
// ============================================================================
// Module   : quadrature_decoder_counter
// Purpose  : Decodes an asynchronous quadrature pair (A/B) into step and
//            direction events and keeps a WIDTH-bit up/down position count.
//            Each phase is synchronised (2 flops) and glitch-filtered before
//            decoding. Both phases changing at once is flagged as a sticky
//            error.
// Ports    : Clk_In          - clock, rising edge
//            Resetb_In       - synchronous active-low reset
//            Quad_A_In/B_In  - asynchronous quadrature phases
//            Enable_In       - 1 = count and emit steps
//            Load_In         - load Load_Value_In into the count
//            Load_Value_In   - value for Load_In
//            Error_Clear_In  - clears the sticky error flag
//            Count_Out       - position count
//            Step_Out        - one-cycle pulse per valid step
//            Up_Downb_Out    - direction of last valid step (1 = up)
//            Error_Out       - sticky illegal-transition flag
// Revision : 1.0 - initial release
// ============================================================================
module quadrature_decoder_counter #(
    parameter int WIDTH      = 8,
    parameter int FILTER_LEN = 3,
    parameter int SATURATE   = 0
) (
    input  logic             Clk_In,
    input  logic             Resetb_In,
    input  logic             Quad_A_In,
    input  logic             Quad_B_In,
    input  logic             Enable_In,
    input  logic             Load_In,
    input  logic [WIDTH-1:0] Load_Value_In,
    input  logic             Error_Clear_In,
    output logic [WIDTH-1:0] Count_Out,
    output logic             Step_Out,
    output logic             Up_Downb_Out,
    output logic             Error_Out
);

    localparam int               C_FCNT_W   = $clog2(FILTER_LEN + 1);
    localparam logic [WIDTH-1:0] C_CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [1:0]       C_INIT_END = 2'd2;

    typedef enum logic [0:0] {
        S_INIT  = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    // Phase pairs are packed as {A, B}
    logic [1:0]                sync1_q, sync2_q;
    logic [1:0]                filt_q, prev_q;
    logic [1:0][C_FCNT_W-1:0]  fcnt_q;
    logic [1:0]                filt_trk;
    logic [1:0][C_FCNT_W-1:0]  fcnt_trk;

    state_t                    state_q, state_d;
    logic [1:0]                init_cnt_q, init_cnt_d;
    logic                      init_load;

    logic [WIDTH-1:0]          count_q, count_d;
    logic                      step_q, step_d;
    logic                      updn_q, updn_d;
    logic                      err_q, err_d;

    logic                      step_up, step_dn, illegal;

    // ------------------------------------------------------------------
    // Per-channel glitch filter: filt follows sync2 only after sync2 has
    // disagreed with it for FILTER_LEN consecutive edges.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_filter
        logic                differ;
        logic [C_FCNT_W-1:0] fcnt_inc;

        assign differ      = (sync2_q[g] != filt_q[g]);
        assign fcnt_inc    = fcnt_q[g] + C_FCNT_W'(1);
        assign filt_trk[g] = (differ && (fcnt_inc == C_FCNT_W'(FILTER_LEN)))
                             ? sync2_q[g] : filt_q[g];
        assign fcnt_trk[g] = (differ && (fcnt_inc != C_FCNT_W'(FILTER_LEN)))
                             ? fcnt_inc : '0;
    end

    // ------------------------------------------------------------------
    // Transition decode of previous vs. current filtered pair.
    // Forward (up) order: 00 -> 10 -> 11 -> 01 -> 00.
    // ------------------------------------------------------------------
    always_comb begin
        step_up = 1'b0;
        step_dn = 1'b0;
        illegal = 1'b0;
        if (state_q == S_TRACK) begin
            case ({prev_q, filt_q})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_up = 1'b1;
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_dn = 1'b1;
                4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        init_load  = 1'b0;
        count_d    = count_q;
        step_d     = 1'b0;
        updn_d     = updn_q;
        err_d      = err_q;

        // A new illegal transition below overrides a coincident clear
        if (Error_Clear_In) begin
            err_d = 1'b0;
        end

        case (state_q)
            S_INIT: begin
                // Third edge after reset release: synchronisers are full,
                // so adopt the current input levels without decoding them.
                if (init_cnt_q == C_INIT_END) begin
                    init_load = 1'b1;
                    state_d   = S_TRACK;
                end else begin
                    init_cnt_d = init_cnt_q + 2'd1;
                end
            end
            S_TRACK: begin
                if (illegal) begin
                    err_d = 1'b1;
                end else if ((step_up || step_dn) && Enable_In) begin
                    step_d = 1'b1;
                    updn_d = step_up;
                    if (step_up) begin
                        if (!((SATURATE != 0) && (count_q == C_CNT_MAX))) begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end else begin
                        if (!((SATURATE != 0) && (count_q == '0))) begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
            end
            default: state_d = S_INIT;
        endcase

        if (Load_In) begin
            count_d = Load_Value_In;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_In) begin
        if (!Resetb_In) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            filt_q     <= '0;
            prev_q     <= '0;
            fcnt_q     <= '0;
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            count_q    <= '0;
            step_q     <= 1'b0;
            updn_q     <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            sync1_q    <= {Quad_A_In, Quad_B_In};
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            count_q    <= count_d;
            step_q     <= step_d;
            updn_q     <= updn_d;
            err_q      <= err_d;
            if (init_load) begin
                filt_q <= sync2_q;
                prev_q <= sync2_q;
                fcnt_q <= '0;
            end else if (state_q == S_TRACK) begin
                filt_q <= filt_trk;
                fcnt_q <= fcnt_trk;
                prev_q <= filt_q;
            end
        end
    end

    assign Count_Out    = count_q;
    assign Step_Out     = step_q;
    assign Up_Downb_Out = updn_q;
    assign Error_Out    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_quadrature_decoder_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_quadrature_decoder_counter
// Purpose  : Self-checking bench for quadrature_decoder_counter. A wrapping
//            and a saturating instance share all inputs; a position-based
//            reference model predicts count, direction, error and pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quadrature_decoder_counter;

    logic       clk = 1'b0;
    logic       rstb, qa, qb, en, ld, eclr;
    logic [7:0] ldv;
    logic [7:0] c0, c1;
    logic       s0, s1, u0, u1, e0, e1;

    int checks   = 0;
    int failures = 0;
    int pulses0  = 0;
    int pulses1  = 0;

    // Reference model state
    bit         ma, mb;
    logic [7:0] m_c0, m_c1;
    bit         m_u, m_e;
    int         m_steps = 0;

    // Position of each {A,B} level in the forward cycle, and its inverse
    int         POS [4] = '{0, 3, 1, 2};
    logic [1:0] INV [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    quadrature_decoder_counter #(.WIDTH(8), .FILTER_LEN(3), .SATURATE(0)) u_dut_wrap (
        .Clk_In(clk), .Resetb_In(rstb), .Quad_A_In(qa), .Quad_B_In(qb),
        .Enable_In(en), .Load_In(ld), .Load_Value_In(ldv), .Error_Clear_In(eclr),
        .Count_Out(c0), .Step_Out(s0), .Up_Downb_Out(u0), .Error_Out(e0)
    );

    quadrature_decoder_counter #(.WIDTH(8), .FILTER_LEN(3), .SATURATE(1)) u_dut_sat (
        .Clk_In(clk), .Resetb_In(rstb), .Quad_A_In(qa), .Quad_B_In(qb),
        .Enable_In(en), .Load_In(ld), .Load_Value_In(ldv), .Error_Clear_In(eclr),
        .Count_Out(c1), .Step_Out(s1), .Up_Downb_Out(u1), .Error_Out(e1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (s0 === 1'b1) pulses0++;
        if (s1 === 1'b1) pulses1++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a new phase level and advance the model by the rules of the
    // quadrature cycle: +1 position = up, -1 = down, +2 = illegal.
    task automatic move(input bit a, input bit b, input int hold);
        int d;
        d  = (POS[{a, b}] - POS[{ma, mb}] + 4) % 4;
        qa = a;
        qb = b;
        if (d == 2) begin
            m_e = 1'b1;
        end else if (d != 0 && en === 1'b1) begin
            m_steps++;
            m_u = (d == 1);
            if (m_u) begin
                m_c0 = m_c0 + 8'd1;
                if (m_c1 != 8'hFF) m_c1 = m_c1 + 8'd1;
            end else begin
                m_c0 = m_c0 - 8'd1;
                if (m_c1 != 8'h00) m_c1 = m_c1 - 8'd1;
            end
        end
        ma = a;
        mb = b;
        tick(hold);
    endtask

    // dir: 1 = up, 0 = down, 2 = illegal (jump two positions)
    task automatic step_dir(input int dir, input int hold);
        int         np;
        logic [1:0] v;
        np = (POS[{ma, mb}] + ((dir == 1) ? 1 : (dir == 0) ? 3 : 2)) % 4;
        v  = INV[np];
        move(v[1], v[0], hold);
    endtask

    task automatic do_load(input logic [7:0] v);
        ld  = 1'b1;
        ldv = v;
        tick(1);
        ld   = 1'b0;
        m_c0 = v;
        m_c1 = v;
    endtask

    task automatic do_reset(input bit a, input bit b);
        qa   = a;
        qb   = b;
        rstb = 1'b0;
        tick(3);
        rstb = 1'b1;
        m_c0 = 8'd0; m_c1 = 8'd0; m_u = 1'b1; m_e = 1'b0;
        ma   = a;    mb   = b;
        tick(6);
    endtask

    task automatic test_reset();
        int p0;
        en = 1'b1; ld = 1'b0; eclr = 1'b0; ldv = 8'd0;
        qa = 1'b1; qb = 1'b1; rstb = 1'b0;
        tick(3);
        checks++;
        if (c0 !== 8'd0 || s0 !== 1'b0 || u0 !== 1'b1 || e0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_values got count=%0d step=%b updn=%b err=%b exp 0/0/1/0", c0, s0, u0, e0);
        end
        p0   = pulses0 + pulses1;
        rstb = 1'b1;
        m_c0 = 8'd0; m_c1 = 8'd0; m_u = 1'b1; m_e = 1'b0; ma = 1'b1; mb = 1'b1;
        tick(10);
        checks++;
        if (c0 !== 8'd0 || c1 !== 8'd0 || e0 !== 1'b0 || e1 !== 1'b0) begin
            failures++;
            $display("FAIL init_from_11 got count=%0d/%0d err=%b/%b exp 0 0", c0, c1, e0, e1);
        end
        checks++;
        if (pulses0 + pulses1 !== p0) begin
            failures++;
            $display("FAIL init_no_step got pulses=%0d exp %0d", pulses0 + pulses1, p0);
        end
    endtask

    task automatic test_forward();
        do_reset(1'b0, 1'b0);
        move(1'b1, 1'b0, 5);
        checks++;
        if (s0 !== 1'b0) begin
            failures++;
            $display("FAIL fwd_latency_early got step=%b exp 0", s0);
        end
        tick(1);
        checks++;
        if (s0 !== 1'b1 || c0 !== 8'd1 || u0 !== 1'b1) begin
            failures++;
            $display("FAIL fwd_latency_edge got step=%b count=%0d updn=%b exp 1 1 1", s0, c0, u0);
        end
        tick(1);
        checks++;
        if (s0 !== 1'b0) begin
            failures++;
            $display("FAIL fwd_pulse_width got step=%b exp 0", s0);
        end
        tick(1);
        move(1'b1, 1'b1, 8);
        move(1'b0, 1'b1, 8);
        move(1'b0, 1'b0, 8);
        checks++;
        if (c0 !== 8'd4 || c1 !== 8'd4 || u0 !== 1'b1 || pulses0 !== 4 || pulses1 !== 4) begin
            failures++;
            $display("FAIL fwd_rotation got count=%0d/%0d updn=%b pulses=%0d/%0d exp 4 4 1 4 4",
                     c0, c1, u0, pulses0, pulses1);
        end
    endtask

    task automatic test_reverse_wrap();
        logic [7:0] exp_wrap [6] = '{8'd0, 8'd255, 8'd254, 8'd253, 8'd252, 8'd251};
        int p0, p1;
        do_load(8'd1);
        p0 = pulses0;
        p1 = pulses1;
        for (int i = 0; i < 6; i++) begin
            step_dir(0, 8);
            checks++;
            if (c0 !== exp_wrap[i] || c1 !== 8'd0) begin
                failures++;
                $display("FAIL rev_step%0d got wrap=%0d sat=%0d exp %0d 0", i, c0, c1, exp_wrap[i]);
            end
        end
        checks++;
        if (u0 !== 1'b0 || u1 !== 1'b0 || pulses0 - p0 !== 6 || pulses1 - p1 !== 6) begin
            failures++;
            $display("FAIL rev_dir_pulses got updn=%b/%b pulses=%0d/%0d exp 0 0 6 6",
                     u0, u1, pulses0 - p0, pulses1 - p1);
        end
    endtask

    task automatic test_glitch_illegal();
        qa = ~ma;
        tick(2);
        qa = ma;
        tick(10);
        checks++;
        if (pulses0 !== m_steps || c0 !== m_c0 || e0 !== 1'b0) begin
            failures++;
            $display("FAIL glitch got pulses=%0d count=%0d err=%b exp %0d %0d 0", pulses0, c0, e0, m_steps, m_c0);
        end
        step_dir(2, 8);
        checks++;
        if (e0 !== 1'b1 || e1 !== 1'b1 || c0 !== m_c0 || pulses0 !== m_steps) begin
            failures++;
            $display("FAIL illegal got err=%b/%b count=%0d pulses=%0d exp 1 1 %0d %0d",
                     e0, e1, c0, pulses0, m_c0, m_steps);
        end
        // Clear lands on the same edge as the next illegal transition
        step_dir(2, 5);
        eclr = 1'b1;
        tick(1);
        eclr = 1'b0;
        checks++;
        if (e0 !== 1'b1 || e1 !== 1'b1) begin
            failures++;
            $display("FAIL clear_vs_illegal got err=%b/%b exp 1 1", e0, e1);
        end
        tick(3);
        eclr = 1'b1;
        tick(1);
        eclr = 1'b0;
        m_e  = 1'b0;
        checks++;
        if (e0 !== 1'b0 || e1 !== 1'b0) begin
            failures++;
            $display("FAIL clear_alone got err=%b/%b exp 0 0", e0, e1);
        end
    endtask

    task automatic test_load_enable();
        step_dir(1, 5);
        ld  = 1'b1;
        ldv = 8'h80;
        tick(1);
        ld   = 1'b0;
        m_c0 = 8'h80;
        m_c1 = 8'h80;
        checks++;
        if (c0 !== 8'h80 || c1 !== 8'h80 || s0 !== 1'b1 || u0 !== 1'b1) begin
            failures++;
            $display("FAIL load_with_step got count=%0h/%0h step=%b updn=%b exp 80 80 1 1", c0, c1, s0, u0);
        end
        tick(3);
        step_dir(0, 8);
        en = 1'b0;
        for (int i = 0; i < 3; i++) step_dir(1, 8);
        checks++;
        if (c0 !== m_c0 || c0 !== 8'h7F || u0 !== 1'b0 || pulses0 !== m_steps) begin
            failures++;
            $display("FAIL enable_off got count=%0h updn=%b pulses=%0d exp 7f 0 %0d", c0, u0, pulses0, m_steps);
        end
        step_dir(2, 8);
        checks++;
        if (e0 !== 1'b1 || c0 !== 8'h7F) begin
            failures++;
            $display("FAIL enable_off_illegal got err=%b count=%0h exp 1 7f", e0, c0);
        end
        en = 1'b1;
    endtask

    task automatic test_midop_reset();
        int         np, p0;
        logic [1:0] v;
        np = (POS[{ma, mb}] + 1) % 4;
        v  = INV[np];
        qa = v[1];
        qb = v[0];
        tick(2);
        rstb = 1'b0;
        tick(1);
        checks++;
        if (c0 !== 8'd0 || c1 !== 8'd0 || s0 !== 1'b0 || u0 !== 1'b1 || e0 !== 1'b0) begin
            failures++;
            $display("FAIL midop_reset got count=%0d/%0d step=%b updn=%b err=%b exp 0 0 0 1 0",
                     c0, c1, s0, u0, e0);
        end
        tick(2);
        rstb = 1'b1;
        m_c0 = 8'd0; m_c1 = 8'd0; m_u = 1'b1; m_e = 1'b0;
        ma   = v[1]; mb   = v[0];
        p0   = pulses0;
        tick(15);
        checks++;
        if (pulses0 !== p0 || c0 !== 8'd0 || e0 !== 1'b0) begin
            failures++;
            $display("FAIL midop_release got pulses=%0d count=%0d err=%b exp %0d 0 0", pulses0, c0, e0, p0);
        end
    endtask

    task automatic test_random();
        logic [7:0] edges [4] = '{8'h00, 8'h01, 8'hFE, 8'hFF};
        for (int i = 0; i < 60; i++) begin
            int r, hold;
            r    = $urandom_range(0, 9);
            hold = $urandom_range(7, 12);
            en   = ($urandom_range(0, 3) != 0);
            if (r < 4)       step_dir(1, hold);
            else if (r < 8)  step_dir(0, hold);
            else if (r == 8) step_dir(2, hold);
            else             move(ma, mb, hold);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) do_load(edges[$urandom_range(0, 3)]);
                else                           do_load(8'($urandom_range(0, 255)));
            end
            if (m_e && $urandom_range(0, 2) == 0) begin
                eclr = 1'b1;
                tick(1);
                eclr = 1'b0;
                m_e  = 1'b0;
            end
            checks++;
            if (c0 !== m_c0 || c1 !== m_c1) begin
                failures++;
                $display("FAIL rand%0d_count got %0d/%0d exp %0d/%0d", i, c0, c1, m_c0, m_c1);
            end
            checks++;
            if (u0 !== m_u || u1 !== m_u) begin
                failures++;
                $display("FAIL rand%0d_updn got %b/%b exp %b", i, u0, u1, m_u);
            end
            checks++;
            if (e0 !== m_e || e1 !== m_e) begin
                failures++;
                $display("FAIL rand%0d_err got %b/%b exp %b", i, e0, e1, m_e);
            end
            checks++;
            if (pulses0 !== m_steps || pulses1 !== m_steps) begin
                failures++;
                $display("FAIL rand%0d_pulses got %0d/%0d exp %0d", i, pulses0, pulses1, m_steps);
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse_wrap();
        test_glitch_illegal();
        test_load_enable();
        test_midop_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/quadrature_decoder_counter.md
# quadrature_decoder_counter

- Converts a two-phase quadrature signal pair (A/B, e.g. from a rotary encoder) into direction and step events, and keeps a WIDTH-bit up/down position count.
- It drives the direction/step side of the same up/down counting scheme used by the team's counter blocks; its Up_Downb_Out/Step_Out pair is directly compatible with an up/down counter's Up_Downb/enable inputs.
- Includes input synchronisation, glitch filtering, illegal-transition detection, load and saturation options.

## Interface
Parameters:
- WIDTH, 8, width of Count_Out and Load_Value_In (>= 2)
- FILTER_LEN, 3, consecutive cycles a synchronised input must differ from its filtered value before the filtered value updates (>= 1)
- SATURATE, 0, 0 = count wraps modulo 2^WIDTH; 1 = count clamps at 0 and 2^WIDTH-1

Ports:
- Clk_In  in  1  clock; all logic on rising edge
- Resetb_In  in  1  reset, synchronous, active-low
- Quad_A_In  in  1  phase A, asynchronous
- Quad_B_In  in  1  phase B, asynchronous
- Enable_In  in  1  1 = count and emit steps; 0 = tracking continues, count frozen, no Step_Out
- Load_In  in  1  synchronous load of Load_Value_In into count
- Load_Value_In  in  WIDTH  load value
- Error_Clear_In  in  1  clears sticky error
- Count_Out  out  WIDTH  position count
- Step_Out  out  1  one-cycle pulse per valid quadrature step
- Up_Downb_Out  out  1  direction of last valid step (1 = up, 0 = down)
- Error_Out  out  1  sticky illegal-transition flag

## Operation
- Input path: each phase passes through a 2-flop synchroniser (sync1, sync2), then a per-channel filter.
  - Each filter has a counter, incremented on every edge where sync2 != filt and cleared on any edge where they match.
  - When the counter would reach FILTER_LEN, filt takes sync2 and the counter clears.
- State machine:
  - INIT: entered on every reset cycle. It stays for 3 edges after the last reset-low edge, covering synchroniser fill plus one load edge.
  - On the third edge, filt{A,B} is loaded directly from sync2 and the counter is cleared. There is no step and no error, whatever level the inputs are at. The machine then moves to TRACK.
  - TRACK: compares the previous filtered pair {A,B} with the new pair every cycle.
- Decode (TRACK), using {A,B}:
  - Forward sequence is 00→10→11→01→00 (A leads B): a valid up step.
  - The reverse sequence is a valid down step.
  - No change: nothing happens.
  - Both bits changing in the same cycle (including both filters updating on the same edge) is illegal. It sets Error_Out, produces no step and no count change, and the new pair is accepted as the current state.
- Valid step with Enable_In=1:
  - Step_Out pulses for 1 cycle.
  - Up_Downb_Out takes the step direction.
  - Count_Out moves by ±1.
- Valid step with Enable_In=0: ignored entirely. Up_Downb_Out holds. Illegal transitions still set Error_Out.
- Width rules:
  - Count arithmetic is WIDTH-bit unsigned.
  - With SATURATE=0, up from 2^WIDTH-1 gives 0 and down from 0 gives 2^WIDTH-1.
  - With SATURATE=1, count holds at the bound, but Step_Out and Up_Downb_Out still update.
- Priority on Count_Out: reset > Load_In > step.
  - A load coinciding with a step loads Load_Value_In exactly.
  - Step_Out and Up_Downb_Out still reflect that step.
- Error_Out stays 1 until Error_Clear_In. If a clear and a new illegal transition land in the same cycle, Error_Out stays 1.

## Timing
- Reset (Resetb_In=0 at an edge) forces at that edge:
  - Count_Out=0, Step_Out=0, Up_Downb_Out=1, Error_Out=0
  - sync/filt/filter counters=0, state=INIT
- Reset mid-operation aborts any pending filter count; the outputs above apply at that edge.
- Latency: an input change meeting setup before edge 0 behaves as follows:
  - It reaches sync2 at edge 1.
  - filt updates at edge 1+FILTER_LEN.
  - Step_Out, Count_Out and Up_Downb_Out update at edge 2+FILTER_LEN. For the default FILTER_LEN=3 that is edge 5.
- A glitch shorter than FILTER_LEN cycles at sync2 never reaches filt.
- Maximum step rate: one step per FILTER_LEN+1 cycles per channel. Faster input is not guaranteed to decode.
- Load_In and Error_Clear_In take effect at the same edge at which they are sampled.
- All outputs are registered.

## Test plan
- Reset/INIT: hold A=B=1 through reset, release, wait 10 cycles → Count_Out=0, Error_Out=0, Step_Out never high.
- Forward rotation: after INIT from 00, drive 00→10→11→01→00, each level held 8 cycles → 4 Step_Out pulses, Up_Downb_Out=1, Count_Out=4. The first pulse comes exactly 5 edges after the first A change.
- Reverse and wrap (SATURATE=0, WIDTH=8): from count 1, drive 6 reverse steps → Count_Out sequence 0, 255, 254, 253, 252, 251; Up_Downb_Out=0. Repeat with SATURATE=1 → count stops at 0 while 6 Step_Out pulses still occur.
- Glitch/illegal: a 2-cycle pulse on A → no step. Changing 00→11 at once → Error_Out=1, count unchanged. Error_Clear_In together with another 11→00 → Error_Out stays 1; a clear alone → 0.
- Load/enable: Load_In with Load_Value_In=0x80 on the same cycle as an up step → Count_Out=0x80, Step_Out=1. With Enable_In=0, 3 up steps → count and Up_Downb_Out unchanged, no Step_Out.
- Reset mid-operation: assert Resetb_In=0 two cycles after an A change (filter pending) → all outputs at reset values next edge; no step emitted after release.
